// File: rtl/nyancat_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : nyancat_frame_loader_if
// Purpose : Control, byte-stream and frame-memory write bundle of the loader.
// Revision: 1.0 - initial release
// ============================================================================
interface nyancat_frame_loader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [3:0]        frame_sel;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, frame_sel, s_data, s_valid,
        input  s_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, frame_sel, s_data, s_valid,
        output s_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/nyancat_frame_loader.sv
`default_nettype none
// ============================================================================
// Module  : nyancat_frame_loader
// Purpose : Unpacks a byte stream (two 4-bit character indices per byte) into
//           one frame of character memory. Optional trailing checksum byte is
//           enabled by defining NYANCAT_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module nyancat_frame_loader #(
    parameter int NUM_FRAMES   = 12,
    parameter int FRAME_PIXELS = 4096,
    parameter int ADDR_W       = 16
) (
    input  wire logic              px_clk,
    input  wire logic              reset,
    nyancat_frame_loader_if.slave  bus
);
    localparam int PIX_W = $clog2(FRAME_PIXELS);

`ifdef NYANCAT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LO = 3'd1, S_HI = 3'd2, S_CHK = 3'd3, S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LO = 3'd1, S_HI = 3'd2, S_DONE = 3'd4
    } state_t;
`endif

    state_t            r_state, w_state_next;
    logic [3:0]        r_frame, w_frame;
    logic [PIX_W-1:0]  r_pix, w_pix;
    logic [3:0]        r_hi_nib, w_hi_nib;
    logic              r_s_ready, w_s_ready;
    logic              r_wr_en, w_wr_en;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [3:0]        r_wr_data, w_wr_data;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic              w_hs;
    logic [ADDR_W-1:0] w_base;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
    logic [7:0]        r_sum, w_sum;
`endif

    // s_ready is registered, so it already reflects LO/CHK in this cycle.
    assign w_hs   = bus.s_valid && r_s_ready;
    assign w_base = ADDR_W'(r_frame) << PIX_W;

    always_ff @(posedge px_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_frame      = r_frame;
        w_pix        = r_pix;
        w_hi_nib     = r_hi_nib;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_err        = r_err;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
        w_sum        = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_busy = 1'b1;
                    if (int'(bus.frame_sel) < NUM_FRAMES) begin
                        w_frame      = bus.frame_sel;
                        w_pix        = '0;
                        w_err        = 1'b0;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
                        w_sum        = 8'd0;
`endif
                        w_state_next = S_LO;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_LO: begin
                if (w_hs) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = w_base | ADDR_W'(r_pix);
                    w_wr_data    = bus.s_data[3:0];
                    w_hi_nib     = bus.s_data[7:4];
`ifdef NYANCAT_LOADER_CHECKSUM_EN
                    w_sum        = r_sum + bus.s_data;
`endif
                    w_state_next = S_HI;
                end
            end
            S_HI: begin
                // The low write address is always even, so setting bit 0 is +1
                // without any chance of carrying into the frame bits.
                w_wr_en   = 1'b1;
                w_wr_addr = {r_wr_addr[ADDR_W-1:1], 1'b1};
                w_wr_data = r_hi_nib;
                w_pix     = r_pix + PIX_W'(2);
                if (r_pix == PIX_W'(FRAME_PIXELS - 2)) begin
`ifdef NYANCAT_LOADER_CHECKSUM_EN
                    w_state_next = S_CHK;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_LO;
                end
            end
`ifdef NYANCAT_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_hs) begin
                    w_err        = (bus.s_data != r_sum);
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_s_ready = (w_state_next == S_LO);
`ifdef NYANCAT_LOADER_CHECKSUM_EN
        if (w_state_next == S_CHK) w_s_ready = 1'b1;
`endif
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_frame   <= '0;
            r_pix     <= '0;
            r_hi_nib  <= '0;
            r_s_ready <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
            r_sum     <= 8'd0;
`endif
        end else begin
            r_frame   <= w_frame;
            r_pix     <= w_pix;
            r_hi_nib  <= w_hi_nib;
            r_s_ready <= w_s_ready;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
            r_sum     <= w_sum;
`endif
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_nyancat_frame_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_nyancat_frame_loader
// Purpose : Self-checking bench: load scenarios from a table, write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nyancat_frame_loader;
    localparam int ADDR_W = 16;

    logic px_clk = 1'b0;
    logic reset  = 1'b1;

    nyancat_frame_loader_if #(.ADDR_W(ADDR_W)) bus();

    nyancat_frame_loader #(
        .NUM_FRAMES   (12),
        .FRAME_PIXELS (4096),
        .ADDR_W       (ADDR_W)
    ) dut (
        .px_clk (px_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        data;
    } wr_t;

    typedef struct {
        logic [3:0] frame;
        logic [7:0] base;
        logic [7:0] step;
        int         gap_pct;
        bit         poke;
        bit         exp_err;
        logic [7:0] cks_xor;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;
    int cyc = 0;

    int                wr_count = 0;
    int                done_count = 0;
    int                done_cyc = 0;
    int                last_wr_cyc = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    always @(posedge px_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    // Write scoreboard and protocol monitor
    initial begin : monitor
        bit  prev_hs;
        bit  prev_done;
        wr_t e;
        prev_hs   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge px_clk);
            if (bus.wr_en === 1'b1) begin
                wr_count++;
                last_wr_cyc  = cyc;
                last_wr_addr = bus.wr_addr;
                chk("busy_during_write", bus.busy, 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.wr_addr, e.addr);
                    chk("wr_data", bus.wr_data, e.data);
                end
            end
            if (prev_hs) chk("ready_low_in_hi", bus.s_ready, 0);
            if (prev_done) chk("busy_after_done", bus.busy, 0);
            if (bus.done === 1'b1) begin
                if (prev_done) fail_now("done_width");
                done_count++;
                done_cyc = cyc;
            end
            prev_hs   = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1) && !reset;
            prev_done = (bus.done === 1'b1);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_wr_en"},   bus.wr_en,   0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_busy"},    bus.busy,    0);
        chk({tag, "_done"},    bus.done,    0);
        chk({tag, "_err"},     bus.err,     0);
    endtask

    // mode 0: no writes expected, 1: low nibble only, 2: both nibbles
    task automatic send_byte(input logic [7:0] b, input logic [ADDR_W-1:0] lo_addr,
                             input int mode, input int gap_pct, output bit ok);
        int  tmo;
        wr_t e;
        ok = 1'b1;
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.s_valid = 1'b0;
            step();
        end
        if (mode >= 1) begin
            e.addr = lo_addr;
            e.data = b[3:0];
            exp_q.push_back(e);
        end
        if (mode == 2) begin
            e.addr = lo_addr + ADDR_W'(1);
            e.data = b[7:4];
            exp_q.push_back(e);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        tmo = 0;
        while (bus.s_ready !== 1'b1 && tmo < 32) begin
            step();
            tmo++;
        end
        if (bus.s_ready !== 1'b1) begin
            fail_now("ready_timeout");
            ok = 1'b0;
            bus.s_valid = 1'b0;
        end else begin
            step();
        end
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_count == d0 && t < 40) begin
            step();
            t++;
        end
        if (done_count == d0) fail_now("done_timeout");
    endtask

    task automatic run_load(input vec_t v);
        int                d0, w0, cs;
        bit                ok;
        logic [7:0]        b, sum;
        logic              exp_err;
        logic [ADDR_W-1:0] base_addr;
        exp_err   = v.exp_err;
`ifdef NYANCAT_LOADER_CHECKSUM_EN
        if (v.cks_xor != 8'd0) exp_err = 1'b1;
`endif
        base_addr = ADDR_W'(32'(v.frame) * 4096);
        d0 = done_count;
        w0 = wr_count;
        bus.frame_sel = v.frame;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        cs = cyc;
        chk("busy_on_start", bus.busy, 1);
        chk("err_on_start", bus.err, v.exp_err);
        if (!v.exp_err) begin
            sum = 8'd0;
            ok  = 1'b1;
            for (int i = 0; i < 2048 && ok; i++) begin
                b   = v.base + 8'(i) * v.step;
                sum = sum + b;
                if (v.poke && (i % 64) == 10) begin
                    bus.frame_sel = 4'd9;
                    bus.start     = 1'b1;
                    bus.s_valid   = 1'b0;
                    step();
                    bus.start = 1'b0;
                end
                send_byte(b, ADDR_W'(32'(base_addr) + 2 * i), 2, v.gap_pct, ok);
            end
`ifdef NYANCAT_LOADER_CHECKSUM_EN
            if (ok) send_byte(sum ^ v.cks_xor, '0, 0, 0, ok);
`endif
            bus.s_valid = 1'b0;
        end
        wait_done(d0);
        chk("done_count", done_count - d0, 1);
        chk("err_final", bus.err, exp_err);
        chk("write_count", wr_count - w0, v.exp_err ? 0 : 4096);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        if (!v.exp_err) begin
            chk("last_addr", last_wr_addr, base_addr + ADDR_W'(4095));
`ifdef NYANCAT_LOADER_CHECKSUM_EN
            chk("done_after_cks", done_cyc > last_wr_cyc, 1);
`else
            chk("done_after_last_write", done_cyc, last_wr_cyc + 1);
`endif
        end else begin
            chk("bad_frame_done_timing", done_cyc, cs + 1);
        end
    endtask

    initial begin : main
        vec_t v;
        int   d0, w0;
        bit   ok;
        bus.start     = 1'b0;
        bus.frame_sel = 4'd0;
        bus.s_data    = 8'd0;
        bus.s_valid   = 1'b0;

        vecs[0] = '{4'd3,  8'h21, 8'h00, 0,  1'b0, 1'b0, 8'h00};
        vecs[1] = '{4'd12, 8'h00, 8'h00, 0,  1'b0, 1'b1, 8'h00};
        vecs[2] = '{4'd0,  8'h10, 8'h01, 0,  1'b0, 1'b0, 8'h00};
        vecs[3] = '{4'd11, 8'h5A, 8'h13, 35, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{4'd15, 8'h00, 8'h00, 0,  1'b0, 1'b1, 8'h00};
        vecs[5] = '{4'd2,  8'hF0, 8'h07, 10, 1'b1, 1'b0, 8'h00};

        reset = 1'b1;
        step();
        step();
        check_reset_vals("por");
        reset = 1'b0;
        step();

        for (int k = 0; k < 6; k++) run_load(vecs[k]);

        // Reset in the middle of frame 4: the low write of byte 100 is the last one.
        d0 = done_count;
        w0 = wr_count;
        bus.frame_sel = 4'd4;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 100 && ok; i++)
            send_byte(8'(i) + 8'h31, ADDR_W'(16'h4000 + 2 * i), (i == 99) ? 1 : 2, 0, ok);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        step();
        step();
        step();
        chk("reset_abort_writes", wr_count - w0, 199);
        chk("reset_abort_queue", exp_q.size(), 0);
        exp_q.delete();
        check_reset_vals("mid_load");
        reset = 1'b0;
        repeat (10) step();
        chk("no_done_after_reset", done_count - d0, 0);
        chk("no_write_after_reset", wr_count - w0, 199);

        v = '{4'd5, 8'h33, 8'h03, 5, 1'b0, 1'b0, 8'h00};
        run_load(v);

`ifdef NYANCAT_LOADER_CHECKSUM_EN
        v = '{4'd1, 8'h01, 8'h00, 0, 1'b0, 1'b0, 8'h00};
        run_load(v);
        v = '{4'd1, 8'h01, 8'h00, 0, 1'b0, 1'b0, 8'h01};
        run_load(v);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
